// File: rtl/contador_pkg.sv
// Shared constants and helpers for the parametrised up/down counter family.
package contador_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;
  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;

  // Bits needed to hold 0..n-1, never less than one bit.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/contador_prescaler.sv
// Enable prescaler: tick fires on every PRESC-th enabled cycle.
// Only built when CONTADOR_PRESCALER_EN is defined.
`ifdef CONTADOR_PRESCALER_EN
module contador_prescaler
  import contador_pkg::*;
#(
  parameter int PRESC = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic enable,
  output logic tick
);

  localparam int PW = clog2(PRESC);
  localparam logic [PW-1:0] LAST = PW'(PRESC - 1);

  logic [PW-1:0] cnt;

  assign tick = enable & (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tick ? '0 : cnt + PW'(1);
    end
  end

endmodule
`endif

// File: rtl/contador_updown_param.sv
// Parametrised up/down counter with load, wrap/saturate bounds and cascade tc.
// Optional enable prescaler selected by CONTADOR_PRESCALER_EN.
module contador_updown_param
  import contador_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_VAL   = 2**WIDTH - 1,
  parameter int RESET_VAL = 0
`ifdef CONTADOR_PRESCALER_EN
  ,
  parameter int PRESC     = 4
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             updown,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] cont,
  output logic             tc,
  output logic             wrapped,
  output logic             sat_flag
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ZERO  = '0;

  logic             step;
  logic             at_max;
  logic             at_min;
  logic [WIDTH-1:0] load_clamp;
  logic [WIDTH-1:0] cont_next;
  logic             wrap_evt;
  logic             sat_evt;

`ifdef CONTADOR_PRESCALER_EN
  contador_prescaler #(
    .PRESC (PRESC)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .clr    (load),
    .enable (enable),
    .tick   (step)
  );
`else
  assign step = enable;
`endif

  assign at_max     = (cont == MAX_V);
  assign at_min     = (cont == ZERO);
  assign load_clamp = (load_val > MAX_V) ? MAX_V : load_val;

  // step already carries enable (and the prescaler gate when present).
  assign tc = step & (((updown == DIR_UP) & at_max) | ((updown == DIR_DOWN) & at_min));

  always_comb begin
    cont_next = cont;
    wrap_evt  = 1'b0;
    sat_evt   = 1'b0;
    if (step) begin
      if (updown == DIR_UP) begin
        if (!at_max) begin
          cont_next = cont + WIDTH'(1);
        end else if (sat_mode == MODE_SAT) begin
          sat_evt = 1'b1;
        end else begin
          cont_next = ZERO;
          wrap_evt  = 1'b1;
        end
      end else begin
        if (!at_min) begin
          cont_next = cont - WIDTH'(1);
        end else if (sat_mode == MODE_SAT) begin
          sat_evt = 1'b1;
        end else begin
          cont_next = MAX_V;
          wrap_evt  = 1'b1;
        end
      end
    end
  end

  // Register stage: reset > load > count.
  always_ff @(posedge clk) begin
    if (reset) begin
      cont     <= RST_V;
      wrapped  <= 1'b0;
      sat_flag <= 1'b0;
    end else if (load) begin
      cont     <= load_clamp;
      wrapped  <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      cont     <= cont_next;
      wrapped  <= wrap_evt;
      sat_flag <= sat_flag | sat_evt;
    end
  end

endmodule

// File: tb/tb_contador_updown_param.sv
// Self-checking bench for contador_updown_param: directed scenarios plus
// randomized traffic against a behavioural model; cascade of two stages.
module tb_contador_updown_param;

  localparam int W    = 4;
  localparam int MAXV = 9;
  localparam int RSTV = 0;
`ifdef CONTADOR_PRESCALER_EN
  localparam int PR = 3;
`else
  localparam int PR = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, enable, updown, load, sat_mode;
  logic [W-1:0] load_val;
  logic [W-1:0] cont;
  logic         tc, wrapped, sat_flag;

  logic         c_en;
  logic [W-1:0] lo_cont, hi_cont;
  logic         lo_tc, lo_wr, lo_sf, hi_tc, hi_wr, hi_sf;

  int checks = 0;
  int errors = 0;

  // Model state
  int m_cont = 0;
  int m_p    = 0;
  bit m_wrap = 1'b0;
  bit m_sat  = 1'b0;
  bit m_valid = 1'b0;

  contador_updown_param #(
    .WIDTH(W), .MAX_VAL(MAXV), .RESET_VAL(RSTV)
`ifdef CONTADOR_PRESCALER_EN
    , .PRESC(PR)
`endif
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .updown(updown), .load(load),
    .load_val(load_val), .sat_mode(sat_mode), .cont(cont), .tc(tc),
    .wrapped(wrapped), .sat_flag(sat_flag)
  );

  contador_updown_param #(.WIDTH(W), .MAX_VAL(MAXV), .RESET_VAL(0)) u_lo (
    .clk(clk), .reset(reset), .enable(c_en), .updown(1'b1), .load(1'b0),
    .load_val(4'd0), .sat_mode(1'b0), .cont(lo_cont), .tc(lo_tc),
    .wrapped(lo_wr), .sat_flag(lo_sf)
  );

  contador_updown_param #(.WIDTH(W), .MAX_VAL(MAXV), .RESET_VAL(0)) u_hi (
    .clk(clk), .reset(reset), .enable(lo_tc), .updown(1'b1), .load(1'b0),
    .load_val(4'd0), .sat_mode(1'b0), .cont(hi_cont), .tc(hi_tc),
    .wrapped(hi_wr), .sat_flag(hi_sf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_tc();
    return {31'd0, (enable && (m_p == PR - 1) &&
                    ((updown && m_cont == MAXV) || (!updown && m_cont == 0)))};
  endfunction

  // One rising edge of the reference behaviour, from the counter's rules.
  task automatic model_step();
    if (reset) begin
      m_cont = RSTV; m_wrap = 0; m_sat = 0; m_p = 0; m_valid = 1;
    end else if (load) begin
      m_cont = (int'(load_val) > MAXV) ? MAXV : int'(load_val);
      m_wrap = 0; m_sat = 0; m_p = 0;
    end else begin
      m_wrap = 0;
      if (enable) begin
        if (m_p == PR - 1) begin
          m_p = 0;
          if (updown) begin
            if (m_cont < MAXV) m_cont = m_cont + 1;
            else if (sat_mode) m_sat = 1;
            else begin m_cont = 0; m_wrap = 1; end
          end else begin
            if (m_cont > 0) m_cont = m_cont - 1;
            else if (sat_mode) m_sat = 1;
            else begin m_cont = MAXV; m_wrap = 1; end
          end
        end else begin
          m_p = m_p + 1;
        end
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    if (m_valid) check("tc", {31'd0, tc}, exp_tc());
    @(posedge clk);
    model_step();
    #1;
    check("cont", {28'd0, cont}, m_cont);
    check("wrapped", {31'd0, wrapped}, {31'd0, m_wrap});
    check("sat_flag", {31'd0, sat_flag}, {31'd0, m_sat});
  endtask

  initial begin
    logic [W-1:0] prev_hi;
    reset = 1; enable = 0; updown = 1; load = 0; load_val = '0; sat_mode = 0; c_en = 0;

    // Reset state
    cycle(); cycle();
    check("reset_cont", {28'd0, cont}, RSTV);
    check("reset_wrapped", {31'd0, wrapped}, 0);
    check("reset_sat", {31'd0, sat_flag}, 0);

    // Up-count with wrap
    reset = 0; enable = 1; updown = 1; sat_mode = 0;
    for (int i = 1; i <= 12; i++) begin
      cycle();
`ifndef CONTADOR_PRESCALER_EN
      check("up_seq", {28'd0, cont}, i % 10);
      check("up_wrap_pulse", {31'd0, wrapped}, (i == 10) ? 1 : 0);
`endif
    end

    // Down from 0: wrap, then saturate at 0
    reset = 1; cycle();
    reset = 0; updown = 0; enable = 1;
    for (int i = 0; i < 3 * PR; i++) cycle();
`ifndef CONTADOR_PRESCALER_EN
    check("down_wrap_val", {28'd0, cont}, 7);
`endif
    sat_mode = 1;
    for (int i = 0; i < 10 * PR; i++) cycle();
    check("down_sat_cont", {28'd0, cont}, 0);
    check("down_sat_flag", {31'd0, sat_flag}, 1);
    check("down_sat_nowrap", {31'd0, wrapped}, 0);

    // Out-of-range load clamps, overrides enable, clears sat_flag
    load = 1; load_val = 4'd13; updown = 1;
    cycle();
    check("load_clamp", {28'd0, cont}, MAXV);
    check("load_clr_sat", {31'd0, sat_flag}, 0);
    load = 0; sat_mode = 0;

    // Reset beats load mid-count
    reset = 1; cycle();
    reset = 0; enable = 1; updown = 1;
    for (int i = 0; i < 3 * PR; i++) cycle();
    reset = 1; load = 1; load_val = 4'd5;
    cycle();
    check("rst_over_load", {28'd0, cont}, 0);
    reset = 0; load = 0;
    for (int i = 0; i < 2 * PR; i++) cycle();
    check("resume_after_rst", {28'd0, cont}, 2);

`ifdef CONTADOR_PRESCALER_EN
    // Prescaler spacing and restart on load
    reset = 1; cycle();
    reset = 0; enable = 1; updown = 1;
    for (int i = 0; i < 9; i++) cycle();
    check("presc_9cyc", {28'd0, cont}, 3);
    cycle(); cycle();
    load = 1; load_val = 4'd0; cycle();
    load = 0;
    cycle(); cycle();
    check("presc_restart_hold", {28'd0, cont}, 0);
    cycle();
    check("presc_restart_step", {28'd0, cont}, 1);
`else
    // Cascade of two stages
    enable = 0;
    reset = 1; cycle();
    reset = 0; c_en = 1;
    for (int i = 0; i < 25; i++) begin
      prev_hi = hi_cont;
      cycle();
      check("casc_lockstep", {31'd0, (hi_cont != prev_hi)}, {31'd0, lo_wr});
    end
    check("casc_lo", {28'd0, lo_cont}, 5);
    check("casc_hi", {28'd0, hi_cont}, 2);
    c_en = 0;
`endif

    // Randomized traffic against the model
    reset = 0;
    for (int i = 0; i < 400; i++) begin
      reset    = ($urandom_range(0, 49) == 0);
      load     = ($urandom_range(0, 9) == 0);
      enable   = ($urandom_range(0, 3) != 0);
      updown   = $urandom_range(0, 1);
      if ($urandom_range(0, 7) == 0) sat_mode = ~sat_mode;
      load_val = W'($urandom_range(0, 15));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
